// File: rtl/imem_loadable.sv
// Loadable instruction memory: sweeps FILL into every word after reset, then serves
// registered fetches and accepts a streamed program from address 0 on request.
module imem_loadable #(
  parameter int unsigned       DATA_W = 16,
  parameter int unsigned       ADDR_W = 7,
  parameter int unsigned       DEPTH  = 128,
  parameter logic [DATA_W-1:0] FILL   = 16'hF000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_err,
  output logic              mem_ready,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_len
);

  localparam int unsigned     IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              oor;

  // ptr never exceeds DEPTH-1 while writing, so the low IW bits always index a real word
  always_comb begin
    we    = 1'b0;
    wdata = FILL;
    if (state == CLEAR) begin
      we = 1'b1;
    end else if (state == LOAD && load_valid) begin
      we    = 1'b1;
      wdata = load_data;
    end
  end

  assign oor = {1'b0, fetch_addr} > LAST;

  always_ff @(posedge clk) begin
    if (we) mem[ptr[IW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      ptr         <= '0;
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      mem_ready   <= 1'b0;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      load_len    <= '0;
    end else begin
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      case (state)
        CLEAR: begin
          ptr <= ptr + (ADDR_W+1)'(1);
          if (ptr == LAST) begin
            state     <= RUN;
            ptr       <= '0;
            mem_ready <= 1'b1;
          end
        end
        RUN: begin
          // a fetch coincident with load_start is served from pre-load content
          if (fetch_req) begin
            fetch_valid <= 1'b1;
            fetch_err   <= oor;
            fetch_data  <= oor ? FILL : mem[fetch_addr[IW-1:0]];
          end
          if (load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            mem_ready  <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            ptr <= ptr + (ADDR_W+1)'(1);
            if (load_last || ptr == LAST) begin
              state      <= RUN;
              load_len   <= ptr + (ADDR_W+1)'(1);
              load_done  <= 1'b1;
              load_ready <= 1'b0;
              mem_ready  <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: 128-word instance for sweep/load/reset cases,
// 100-word instance for non-power-of-two bounds.
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        fetch_req = 1'b0;
  logic [6:0]  fetch_addr = '0;
  logic [15:0] fetch_data;
  logic        fetch_valid, fetch_err, mem_ready;
  logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_ready, load_done;
  logic [7:0]  load_len;

  logic        b_fetch_req = 1'b0;
  logic [6:0]  b_fetch_addr = '0;
  logic [15:0] b_fetch_data;
  logic        b_fetch_valid, b_fetch_err, b_mem_ready;
  logic        b_load_start = 1'b0, b_load_valid = 1'b0;
  logic [15:0] b_load_data = '0;
  logic        b_load_ready, b_load_done;
  logic [7:0]  b_load_len;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [15:0] prog [13] = '{16'h0000, 16'h5015, 16'hC551, 16'h5025, 16'hC552, 16'h5035,
                             16'hC553, 16'h6001, 16'h7002, 16'hA123, 16'hB456, 16'h1234,
                             16'h8005};

  imem_loadable #(.DATA_W(16), .ADDR_W(7), .DEPTH(128), .FILL(16'hF000)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .fetch_err(fetch_err), .mem_ready(mem_ready),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_len(load_len)
  );

  imem_loadable #(.DATA_W(16), .ADDR_W(7), .DEPTH(100), .FILL(16'hF000)) dut100 (
    .clk(clk), .rst(rst),
    .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr), .fetch_data(b_fetch_data),
    .fetch_valid(b_fetch_valid), .fetch_err(b_fetch_err), .mem_ready(b_mem_ready),
    .load_start(b_load_start), .load_valid(b_load_valid), .load_data(b_load_data),
    .load_last(1'b0), .load_ready(b_load_ready), .load_done(b_load_done),
    .load_len(b_load_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset state, clear sweep timing, FILL fetches
    tick();
    rst = 1'b1;
    #2;
    check("rst_fetch_data", fetch_data, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_load_len", load_len, 0);
    check("rst_load_done", load_done, 0);
    tick();
    rst = 1'b0;
    check("clr_ready_c0", mem_ready, 0);
    for (int k = 1; k <= 128; k++) begin
      tick();
      check($sformatf("clr_ready_c%0d", k), mem_ready, (k == 128) ? 1 : 0);
      check($sformatf("clr_ldready_c%0d", k), load_ready, 0);
    end
    fetch_req = 1'b1; fetch_addr = 7'd0;
    tick();
    check("t1_f0_valid", fetch_valid, 1);
    check("t1_f0_data", fetch_data, 16'hF000);
    fetch_addr = 7'd5;
    tick();
    check("t1_f5_data", fetch_data, 16'hF000);
    fetch_addr = 7'd127;
    tick();
    check("t1_f127_data", fetch_data, 16'hF000);
    check("t1_f127_err", fetch_err, 0);
    fetch_req = 1'b0;
    tick();
    check("t1_idle_valid", fetch_valid, 0);
    check("t1_idle_hold", fetch_data, 16'hF000);

    // 2: 13-word program terminated by load_last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t2_load_ready", load_ready, 1);
    check("t2_mem_ready", mem_ready, 0);
    for (int i = 0; i < 13; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 12);
      tick();
      if (i < 12) check("t2_no_done", load_done, 0);
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("t2_done", load_done, 1);
    check("t2_len", load_len, 13);
    check("t2_ldready_off", load_ready, 0);
    check("t2_memready_on", mem_ready, 1);
    fetch_req = 1'b1;
    for (int i = 0; i < 13; i++) begin
      fetch_addr = 7'(i);
      tick();
      if (i == 0) check("t2_done_pulse", load_done, 0);
      check($sformatf("t2_rd%0d_valid", i), fetch_valid, 1);
      check($sformatf("t2_rd%0d", i), fetch_data, prog[i]);
    end
    fetch_addr = 7'd13;
    tick();
    check("t2_rd13", fetch_data, 16'hF000);
    fetch_req = 1'b0;
    tick();

    // 3: 130 words, no load_last: stops after word 127
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 130; i++) begin
      load_valid = 1'b1; load_data = 16'h1000 + 16'(i);
      tick();
      if (i == 127) begin
        check("t3_done", load_done, 1);
        check("t3_len", load_len, 128);
        check("t3_ldready_off", load_ready, 0);
      end
      if (i == 128) check("t3_done_once", load_done, 0);
    end
    load_valid = 1'b0;
    check("t3_len_hold", load_len, 128);
    fetch_req = 1'b1; fetch_addr = 7'd0;
    tick();
    check("t3_rd0", fetch_data, 16'h1000);
    fetch_addr = 7'd1;
    tick();
    check("t3_rd1", fetch_data, 16'h1001);
    fetch_addr = 7'd127;
    tick();
    check("t3_rd127", fetch_data, 16'h107F);
    fetch_req = 1'b0;
    tick();

    // 4: DEPTH=100 bounds, after filling all 100 words
    check("t4_ready", b_mem_ready, 1);
    b_load_start = 1'b1;
    tick();
    b_load_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      b_load_valid = 1'b1; b_load_data = 16'h2000 + 16'(i);
      tick();
    end
    b_load_valid = 1'b0;
    check("t4_done", b_load_done, 1);
    check("t4_len", b_load_len, 100);
    b_fetch_req = 1'b1; b_fetch_addr = 7'd99;
    tick();
    check("t4_rd99_valid", b_fetch_valid, 1);
    check("t4_rd99", b_fetch_data, 16'h2063);
    check("t4_rd99_err", b_fetch_err, 0);
    b_fetch_addr = 7'd100;
    tick();
    check("t4_rd100", b_fetch_data, 16'hF000);
    check("t4_rd100_err", b_fetch_err, 1);
    b_fetch_addr = 7'd127;
    tick();
    check("t4_rd127", b_fetch_data, 16'hF000);
    check("t4_rd127_err", b_fetch_err, 1);
    b_fetch_req = 1'b0;
    tick();
    check("t4_err_clear", b_fetch_err, 0);

    // 5: fetch and load_start together
    fetch_req = 1'b1; fetch_addr = 7'd1; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t5_valid", fetch_valid, 1);
    check("t5_old", fetch_data, 16'h1001);
    tick();
    fetch_req = 1'b0;
    check("t5_valid_off", fetch_valid, 0);
    check("t5_ldready", load_ready, 1);

    // 6: async reset mid-load discards partial program
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = 16'hD000 + 16'(i);
      tick();
    end
    load_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_data", fetch_data, 0);
    check("t6_rst_ldready", load_ready, 0);
    check("t6_rst_len", load_len, 0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      load_start = (k == 10 || k == 60);
      load_valid = 1'b1; load_data = 16'hEEEE;
      fetch_req  = (k == 20);
      tick();
      if (k == 21) check("t6_clr_fetch", fetch_valid, 0);
      if (k == 61) check("t6_clr_ldready", load_ready, 0);
    end
    load_start = 1'b0; load_valid = 1'b0;
    check("t6_ready", mem_ready, 1);
    check("t6_ldready", load_ready, 0);
    fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = 7'(i);
      tick();
      check($sformatf("t6_rd%0d", i), fetch_data, 16'hF000);
    end
    fetch_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
